uart_rx_param_deserializer: RTL
===============================

# uart_rx_param_deserializer

Parametrised serial-to-parallel converter for the UART receive path. It collects data bits delivered by the bit-sampling logic under control of the RX frame FSM and assembles them into a right-justified word. Width, bit order and per-frame data length are configurable. It emits a one-cycle valid strobe on the same edge that captures the final bit, and supports a synchronous frame abort. It sits between the RX data sampler and the RX parity/stop checker, and replaces the fixed 8-bit deserializer.

## Interface

Parameters:
- DATA_WIDTH, default 8: maximum data bits per frame and width of p_data; legal values 2..16.
- CNT_WIDTH (local, derived): $clog2(DATA_WIDTH+1); width of data_len and bit_cnt.

Ports:
- clk  input  1  single clock for the block; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- sampled_bit  input  1  current sampled RX data bit; valid only when done=1.
- done  input  1  one-cycle strobe from the sampler: sampled_bit is valid this cycle.
- deser_en  input  1  high while the RX FSM is in its data phase.
- frame_clr  input  1  synchronous abort/restart (start-bit detect, framing error).
- msb_first  input  1  bit order: 0 = first bit is LSB, 1 = first bit is MSB. Latched on the first accepted bit of a frame.
- data_len  input  CNT_WIDTH  data bits per frame. Latched on the first accepted bit. Value 0 or >DATA_WIDTH is treated as DATA_WIDTH.
- p_data  output  DATA_WIDTH  last completed word, right-justified, unused upper bits 0; held until the next completion.
- p_valid  output  1  one-cycle pulse: p_data updated this cycle.
- busy  output  1  a frame is partially assembled (1 ≤ bit_cnt < length).
- bit_cnt  output  CNT_WIDTH  bits accepted in the current frame.

## Operation

- States:
  - IDLE: bit_cnt=0, busy=0.
  - SHIFT: busy=1.
- Accept condition: done && deser_en && !frame_clr. No bit is accepted in any other cycle.
- First accepted bit (IDLE → SHIFT, or straight to completion if length=1):
  - latch msb_first → ord_q;
  - latch the effective data_len → len_q;
  - clear the shift register before inserting the bit.
- Bit insertion:
  - LSB-first: sh[bit_cnt] <= sampled_bit.
  - MSB-first: sh <= {sh[DATA_WIDTH-2:0], sampled_bit}.
  - Both modes yield a right-justified result.
- Completion, when the accepted bit is bit number len_q (bit_cnt == len_q-1):
  - p_data <= completed word, zero-masked above len_q;
  - p_valid <= 1;
  - bit_cnt <= 0; state → IDLE.
- Otherwise bit_cnt increments. The counter never exceeds len_q-1 and never wraps.
- deser_en low mid-frame: incoming bits are ignored; the partial frame, bit_cnt and busy are held.
- frame_clr (highest priority after reset):
  - bit_cnt, shift register and state are cleared; busy=0;
  - p_data holds its value; p_valid=0.
  - A done in the same cycle is discarded.
- Changes to msb_first and data_len mid-frame have no effect until the next frame.
- Reset values: p_data=0, p_valid=0, busy=0, bit_cnt=0, internal shift register=0, state=IDLE.
- Reset asserted mid-frame: the partial frame is lost and no p_valid is issued.

## Timing

- Latency: p_valid and the new p_data appear on the clock edge that samples the final done. There is no extra load cycle.
- p_valid is exactly one cycle wide. It is never high in two consecutive cycles unless len_q=1 and done is high in consecutive cycles.
- Back-to-back frames: a done in the cycle directly after completion is accepted as bit 1 of a new frame.
- No backpressure: the consumer must capture p_data when p_valid=1. p_data remains stable until the next completion.
- busy and bit_cnt are registered and update on the same edge as the accepted bit.

## Test plan

- Reset, DATA_WIDTH=8, msb_first=0, data_len=8; feed bits 1,0,1,1,0,0,1,0 → p_data=0x4D. Single p_valid pulse on the 8th-bit edge. busy high after bits 1..7, low after bit 8.
- Same bits with msb_first=1 → p_data=0xB2. Toggling msb_first after bit 3 → still 0xB2.
- data_len=5, LSB-first bits 1,1,0,0,1 → p_data=0x13. Same bits MSB-first → 0x19. data_len=0 with bits for 0xFF → 0xFF after 8 bits.
- Complete a 0x3C frame, then 3 bits, frame_clr, then an 8-bit 0xA5 frame:
  - p_data stays 0x3C through the abort; no p_valid at the abort;
  - then 0xA5 with exactly one p_valid.
  - Also apply done together with frame_clr: the bit is discarded and bit_cnt=0.
- Mid-frame: pulse done with deser_en=0 → bit_cnt unchanged. Then assert rst after 4 bits → all outputs 0, no p_valid. The next full frame 0x81 → p_data=0x81.
- Back-to-back: two 8-bit frames 0x55 then 0xAA, with done every cycle → p_valid on cycles 8 and 16, p_data=0x55 then 0xAA.

Source files
------------

// File: rtl/uart_rx_param_deserializer_if.sv
// uart_rx_param_deserializer_if: sampler/FSM side bits in, assembled word and status out
interface uart_rx_param_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    logic                  sampled_bit;
    logic                  done;
    logic                  deser_en;
    logic                  frame_clr;
    logic                  msb_first;
    logic [CNT_WIDTH-1:0]  data_len;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  p_valid;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    modport master (
        output sampled_bit, done, deser_en, frame_clr, msb_first, data_len,
        input  p_data, p_valid, busy, bit_cnt
    );
    modport slave (
        input  sampled_bit, done, deser_en, frame_clr, msb_first, data_len,
        output p_data, p_valid, busy, bit_cnt
    );
endinterface

// File: rtl/uart_rx_param_deserializer.sv
// uart_rx_param_deserializer: assembles sampled RX bits into a right-justified word of configurable length/order
module uart_rx_param_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input logic                         clk,
    input logic                         rst,
    uart_rx_param_deserializer_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, p_data_q, p_data_d, sh_base, sh_ins, mask;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d, len_q, len_d, eff_len, len_use;
    logic                  ord_q, ord_d, p_valid_q, p_valid_d;
    logic                  accept, first, ord_use, last;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q      <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            bit_cnt_q <= '0;
            len_q     <= CW'(DATA_WIDTH);
            ord_q     <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            ord_q     <= ord_d;
        end
    end
    // Frame parameters come straight from the inputs on the first bit, from the latches afterwards
    always_comb begin
        accept    = bus.done && bus.deser_en && !bus.frame_clr;
        first     = state_q == IDLE;
        eff_len   = (bus.data_len == '0 || bus.data_len > CW'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : bus.data_len;
        len_use   = first ? eff_len : len_q;
        ord_use   = first ? bus.msb_first : ord_q;
        sh_base   = first ? '0 : sh_q;
        sh_ins    = ord_use ? {sh_base[DATA_WIDTH-2:0], bus.sampled_bit}
                            : sh_base | (DATA_WIDTH'(bus.sampled_bit) << bit_cnt_q);
        mask      = ~({DATA_WIDTH{1'b1}} << len_use);
        last      = bit_cnt_q == len_use - 1'b1;
        len_d     = (accept && first) ? len_use : len_q;
        ord_d     = (accept && first) ? ord_use : ord_q;
        sh_d      = bus.frame_clr ? '0 : accept ? sh_ins : sh_q;
        bit_cnt_d = bus.frame_clr ? '0 : accept ? (last ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
        p_valid_d = accept && last;
        p_data_d  = p_valid_d ? (sh_ins & mask) : p_data_q;
    end
    always_comb begin
        state_d = bus.frame_clr ? IDLE : accept ? (last ? IDLE : SHIFT) : state_q;
    end
    always_comb begin
        bus.busy    = state_q == SHIFT;
        bus.p_data  = p_data_q;
        bus.p_valid = p_valid_q;
        bus.bit_cnt = bit_cnt_q;
    end
endmodule
